trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
- Sits downstream of the exception-signal decode stage. Consumes its fetch-stage and execute-stage exception codes.
- Carries each fetch-stage code alongside its instruction through the F->D and D->E pipeline registers, so traps are taken precisely at execute.
- Runs the trap-entry / trap-return state machine: captures mepc/mcause/mtval, flushes the front end, redirects the PC, and owns the reset_permission and trap_permission flags fed back to the decode stage.

Parameters:
- TRAP_VECTOR, 32'h0000_0000, trap handler entry (pc[20:18]=000 region).
- TEXT_BASE, 32'h0008_0000, user text entry after reset code completes (pc[20:18]=010).
- NO_E_CODE, 4'hF, "no exception" code; all other codes are cause values (0 fetch misaligned, 2 illegal, 4/5 load misaligned/fault, 6/7 store misaligned/fault, 11 ecall, 14 sp out of range).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_stall_f  in  1  hazard-unit stall of the F->D register.
- i_stall_d  in  1  hazard-unit stall of the D->E register.
- i_flush_d  in  1  hazard-unit flush of D (branch taken).
- i_flush_e  in  1  hazard-unit flush of E.
- i_pc_f  in  32  fetch PC.
- i_exception_code_f  in  4  fetch-stage code.
- i_exception_code_e  in  4  execute-stage code.
- i_alu_out_e  in  32  execute ALU result (load/store address).
- i_mret_e  in  1  mret in execute.
- i_reset_done_e  in  1  reset-code exit instruction in execute.
- o_pc_redirect_en  out  1  PC mux override, single cycle.
- o_pc_redirect  out  32  redirect target.
- o_flush_fde  out  1  flush F/D and D/E registers.
- o_trap_taken  out  1  single-cycle pulse on trap entry.
- o_mepc  out  32  faulting PC.
- o_mcause  out  4  trap cause.
- o_mtval  out  32  fault value.
- o_trap_permission  out  1  handler region enabled.
- o_reset_permission  out  1  reset region enabled.
- o_halt  out  1  double-fault halt, sticky.

Behaviour:
- Reset (async, i_rst=1): state RESET_CODE. o_reset_permission=1, o_trap_permission=0, o_halt=0. o_mepc=0, o_mtval=0, o_mcause=NO_E_CODE. All pulses are 0. Pipelined code and PC registers are cleared to NO_E_CODE / 0.
- Code pipeline: code_d/pc_d load i_exception_code_f/i_pc_f unless i_stall_f. code_e/pc_e load code_d/pc_d unless i_stall_d.
- The D register loads NO_E_CODE on i_flush_d or o_flush_fde. The E register loads NO_E_CODE on i_flush_e or o_flush_fde. Flush beats stall.
- Effective cause at E:
  - code_e when code_e != NO_E_CODE (fetch fault wins for the same instruction);
  - else i_exception_code_e;
  - else none.
- mtval selection:
  - pc_e for causes 0 and 2;
  - i_alu_out_e for causes 4, 5, 6, 7 and 14;
  - 0 for cause 11.
- States:
  - RESET_CODE:
    - Effective cause present -> HALT.
    - i_reset_done_e -> RET_TEXT.
  - RET_TEXT (1 cycle): o_pc_redirect_en=1, o_pc_redirect=TEXT_BASE, o_flush_fde=1. reset_permission cleared at the exiting edge. -> RUN.
  - RUN: effective cause present -> ENTER. At that edge, latch mepc=pc_e, mcause, mtval.
  - ENTER (1 cycle): o_pc_redirect_en=1, o_pc_redirect=TRAP_VECTOR, o_flush_fde=1, o_trap_taken=1. trap_permission set at the exiting edge. -> HANDLER.
  - HANDLER:
    - Effective cause present -> HALT. Nested traps are unsupported; mepc/mcause stay unchanged.
    - i_mret_e -> RETURN.
  - RETURN (1 cycle): o_pc_redirect_en=1, o_pc_redirect=o_mepc, o_flush_fde=1. trap_permission cleared at the exiting edge. mcause reset to NO_E_CODE. -> RUN.
  - HALT: o_halt=1 and o_flush_fde=1 held every cycle; exits only on reset.
- Latency: fault visible at E at cycle N -> redirect asserted in cycle N+1 -> fetch from TRAP_VECTOR at cycle N+2.
- Simultaneous events:
  - Effective cause together with i_mret_e in HANDLER -> HALT.
  - Effective cause together with i_reset_done_e in RESET_CODE -> HALT.
  - A fault in an instruction behind one being flushed never traps (its code is replaced by NO_E_CODE).
- ecall: mepc = pc of the ecall; software advances mepc before mret.
- Stall during RUN: a held E register with a pending cause still traps once. ENTER flushes E, so no re-trigger.
- Reset mid-ENTER/HANDLER/RETURN: immediate return to RESET_CODE with all outputs at reset values.

Test Plan:
1. Reset, then i_reset_done_e at cycle 5 -> cycle 6: redirect=0x0008_0000, flush=1. Cycle 7: reset_permission=0, trap_permission=0, state RUN.
2. RUN, i_exception_code_f=0 with i_pc_f=0x0008_0006, no stalls -> two cycles later code reaches E. Next cycle: redirect=0x0, trap_taken=1, mcause=0, mepc=mtval=0x0008_0006. Following cycle: trap_permission=1.
3. RUN, i_exception_code_e=5, pc_e=0x0008_0010, alu_out=0x0000_1000 -> mcause=5, mtval=0x1000, mepc=0x0008_0010. Then i_mret_e -> redirect=0x0008_0010, trap_permission=0, mcause=0xF.
4. Fetch code 2 on an instruction flushed by i_flush_d -> no trap_taken ever. Same code with i_stall_d held 3 cycles -> exactly one trap_taken pulse.
5. HANDLER, i_exception_code_e=11 -> o_halt=1 and flush=1 sticky, mepc unchanged. Assert i_rst -> halt=0, reset_permission=1 immediately (async).
6. Same instruction: code_e=0 (fetch) and i_exception_code_e=7 -> mcause=0, mtval=pc_e.

Source files
------------

// File: rtl/trap_sequencer.sv
// Trap-entry / trap-return sequencer: carries fetch exception codes to E,
// takes precise traps there, and owns the reset/trap permission flags.
module trap_sequencer #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TEXT_BASE   = 32'h0008_0000,
    parameter logic [3:0]  NO_E_CODE   = 4'hF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall_f,
    input  logic        i_stall_d,
    input  logic        i_flush_d,
    input  logic        i_flush_e,
    input  logic [31:0] i_pc_f,
    input  logic [3:0]  i_exception_code_f,
    input  logic [3:0]  i_exception_code_e,
    input  logic [31:0] i_alu_out_e,
    input  logic        i_mret_e,
    input  logic        i_reset_done_e,
    output logic        o_pc_redirect_en,
    output logic [31:0] o_pc_redirect,
    output logic        o_flush_fde,
    output logic        o_trap_taken,
    output logic [31:0] o_mepc,
    output logic [3:0]  o_mcause,
    output logic [31:0] o_mtval,
    output logic        o_trap_permission,
    output logic        o_reset_permission,
    output logic        o_halt
);

    typedef enum logic [2:0] {
        S_RESET_CODE,
        S_RET_TEXT,
        S_RUN,
        S_ENTER,
        S_HANDLER,
        S_RETURN,
        S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  code_d_q, code_e_q;
    logic [31:0] pc_d_q, pc_e_q;
    logic [31:0] mepc_q, mepc_d;
    logic [3:0]  mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic        tperm_q, tperm_d;
    logic        rperm_q, rperm_d;

    logic [3:0]  cause_e;
    logic        cause_vld;
    logic [31:0] mtval_sel;

    // A fetch fault carried with the instruction outranks its execute fault
    always_comb begin
        cause_e   = (code_e_q != NO_E_CODE) ? code_e_q : i_exception_code_e;
        cause_vld = (cause_e != NO_E_CODE);
        case (cause_e)
            4'd0, 4'd2:                       mtval_sel = pc_e_q;
            4'd4, 4'd5, 4'd6, 4'd7, 4'd14:    mtval_sel = i_alu_out_e;
            default:                          mtval_sel = 32'h0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            code_d_q <= NO_E_CODE;
            code_e_q <= NO_E_CODE;
            pc_d_q   <= 32'h0;
            pc_e_q   <= 32'h0;
        end else begin
            if (i_flush_d || o_flush_fde) begin
                code_d_q <= NO_E_CODE;
            end else if (!i_stall_f) begin
                code_d_q <= i_exception_code_f;
            end
            if (!i_stall_f) begin
                pc_d_q <= i_pc_f;
            end
            if (i_flush_e || o_flush_fde) begin
                code_e_q <= NO_E_CODE;
            end else if (!i_stall_d) begin
                code_e_q <= code_d_q;
            end
            if (!i_stall_d) begin
                pc_e_q <= pc_d_q;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_RESET_CODE;
            mepc_q   <= 32'h0;
            mcause_q <= NO_E_CODE;
            mtval_q  <= 32'h0;
            tperm_q  <= 1'b0;
            rperm_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q  <= mtval_d;
            tperm_q  <= tperm_d;
            rperm_q  <= rperm_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        mtval_d          = mtval_q;
        tperm_d          = tperm_q;
        rperm_d          = rperm_q;
        o_pc_redirect_en = 1'b0;
        o_pc_redirect    = 32'h0;
        o_flush_fde      = 1'b0;
        o_trap_taken     = 1'b0;
        o_halt           = 1'b0;
        case (state_q)
            S_RESET_CODE: begin
                if (cause_vld) begin
                    state_d = S_HALT;
                end else if (i_reset_done_e) begin
                    state_d = S_RET_TEXT;
                end
            end
            S_RET_TEXT: begin
                o_pc_redirect_en = 1'b1;
                o_pc_redirect    = TEXT_BASE;
                o_flush_fde      = 1'b1;
                rperm_d          = 1'b0;
                state_d          = S_RUN;
            end
            S_RUN: begin
                if (cause_vld) begin
                    state_d  = S_ENTER;
                    mepc_d   = pc_e_q;
                    mcause_d = cause_e;
                    mtval_d  = mtval_sel;
                end
            end
            S_ENTER: begin
                o_pc_redirect_en = 1'b1;
                o_pc_redirect    = TRAP_VECTOR;
                o_flush_fde      = 1'b1;
                o_trap_taken     = 1'b1;
                tperm_d          = 1'b1;
                state_d          = S_HANDLER;
            end
            S_HANDLER: begin
                // Nested traps are unsupported, so any fault here is fatal
                if (cause_vld) begin
                    state_d = S_HALT;
                end else if (i_mret_e) begin
                    state_d = S_RETURN;
                end
            end
            S_RETURN: begin
                o_pc_redirect_en = 1'b1;
                o_pc_redirect    = mepc_q;
                o_flush_fde      = 1'b1;
                tperm_d          = 1'b0;
                mcause_d         = NO_E_CODE;
                state_d          = S_RUN;
            end
            S_HALT: begin
                o_halt      = 1'b1;
                o_flush_fde = 1'b1;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    assign o_mepc             = mepc_q;
    assign o_mcause           = mcause_q;
    assign o_mtval            = mtval_q;
    assign o_trap_permission  = tperm_q;
    assign o_reset_permission = rperm_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed vector table,
// hand-written corner sequences, and random stimulus against a model.
module tb_trap_sequencer;

    localparam logic [31:0] TEXT = 32'h0008_0000;
    localparam logic [31:0] P0   = 32'h0008_0100;
    localparam logic [3:0]  NOE  = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f, stall_d, flush_d, flush_e;
    logic [31:0] pc_f, alu;
    logic [3:0]  code_f, code_e;
    logic        mret, rdone;
    logic        ren, fl, tt, tp, rp, h;
    logic [31:0] tgt, mepc, mtval;
    logic [3:0]  mc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    trap_sequencer dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_stall_f          (stall_f),
        .i_stall_d          (stall_d),
        .i_flush_d          (flush_d),
        .i_flush_e          (flush_e),
        .i_pc_f             (pc_f),
        .i_exception_code_f (code_f),
        .i_exception_code_e (code_e),
        .i_alu_out_e        (alu),
        .i_mret_e           (mret),
        .i_reset_done_e     (rdone),
        .o_pc_redirect_en   (ren),
        .o_pc_redirect      (tgt),
        .o_flush_fde        (fl),
        .o_trap_taken       (tt),
        .o_mepc             (mepc),
        .o_mcause           (mc),
        .o_mtval            (mtval),
        .o_trap_permission  (tp),
        .o_reset_permission (rp),
        .o_halt             (h)
    );

    // Model: mode 0 boot code, 1 user, 2 handler, 3 dead.
    // ev is the one-cycle redirect in flight: 0 none, 1 text, 2 trap, 3 ret.
    int          m_mode, m_ev;
    logic [3:0]  m_dc, m_ec, m_mc;
    logic [31:0] m_dp, m_ep, m_mepc, m_mtval;
    logic        m_tp, m_rp;

    task automatic model_reset();
        m_mode = 0; m_ev = 0;
        m_dc = NOE; m_ec = NOE; m_dp = 0; m_ep = 0;
        m_mepc = 0; m_mc = NOE; m_mtval = 0; m_tp = 0; m_rp = 1;
    endtask

    function automatic logic [31:0] fault_val(logic [3:0] c, logic [31:0] pc,
                                              logic [31:0] a);
        if (c == 4'd0 || c == 4'd2) return pc;
        if (c inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd14}) return a;
        return 32'h0;
    endfunction

    task automatic model_step();
        logic       fnow;
        logic [3:0] eff, ndc, nec;
        logic [31:0] ndp, nep;
        fnow = (m_ev != 0) || (m_mode == 3);
        eff  = (m_ec != NOE) ? m_ec : code_e;
        nec  = (flush_e || fnow) ? NOE : (stall_d ? m_ec : m_dc);
        nep  = stall_d ? m_ep : m_dp;
        ndc  = (flush_d || fnow) ? NOE : (stall_f ? m_dc : code_f);
        ndp  = stall_f ? m_dp : pc_f;
        if (m_mode != 3) begin
            if (m_ev == 1) begin
                m_rp = 0; m_mode = 1; m_ev = 0;
            end else if (m_ev == 2) begin
                m_tp = 1; m_mode = 2; m_ev = 0;
            end else if (m_ev == 3) begin
                m_tp = 0; m_mc = NOE; m_mode = 1; m_ev = 0;
            end else if (m_mode == 0) begin
                if (eff != NOE) m_mode = 3;
                else if (rdone) m_ev = 1;
            end else if (m_mode == 1) begin
                if (eff != NOE) begin
                    m_ev = 2; m_mepc = m_ep; m_mc = eff;
                    m_mtval = fault_val(eff, m_ep, alu);
                end
            end else begin
                if (eff != NOE) m_mode = 3;
                else if (mret) m_ev = 3;
            end
        end
        m_dc = ndc; m_dp = ndp; m_ec = nec; m_ep = nep;
    endtask

    function automatic logic [105:0] model_vec();
        logic [31:0] t;
        t = (m_ev == 1) ? TEXT : (m_ev == 3) ? m_mepc : 32'h0;
        return {m_ev != 0, t, (m_ev != 0) || (m_mode == 3), m_ev == 2,
                m_mc, m_mepc, m_mtval, m_tp, m_rp, m_mode == 3};
    endfunction

    function automatic logic [105:0] dut_vec();
        return {ren, tgt, fl, tt, mc, mepc, mtval, tp, rp, h};
    endfunction

    task automatic check(string name, logic [105:0] act, logic [105:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check1(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        stall_f = 0; stall_d = 0; flush_d = 0; flush_e = 0;
        pc_f = P0; code_f = NOE; code_e = NOE; alu = 0;
        mret = 0; rdone = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        check("reset", dut_vec(), model_vec());
    endtask

    typedef struct {
        logic [3:0]  cf;
        logic [31:0] pf;
        logic [3:0]  ce;
        logic [31:0] a;
        logic        mr, rd;
        logic        ren;
        logic [31:0] tgt;
        logic        fl, tt;
        logic [3:0]  mc;
        logic [31:0] mepc, mtval;
        logic        tp, rp, h;
    } vec_t;

    vec_t vt[21];

    initial begin
        int tcnt;
        logic [31:0] saved;
        rst = 1;
        idle();
        model_reset();

        vt[0]  = '{NOE, P0, NOE, 0, 0, 0,  0, 0, 0, 0, NOE, 0, 0, 0, 1, 0};
        vt[1]  = '{NOE, P0, NOE, 0, 0, 1,  1, TEXT, 1, 0, NOE, 0, 0, 0, 1, 0};
        vt[2]  = '{NOE, P0, NOE, 0, 0, 0,  0, 0, 0, 0, NOE, 0, 0, 0, 0, 0};
        vt[3]  = '{4'd0, 32'h0008_0006, NOE, 0, 0, 0,
                   0, 0, 0, 0, NOE, 0, 0, 0, 0, 0};
        vt[4]  = '{NOE, P0, NOE, 0, 0, 0,  0, 0, 0, 0, NOE, 0, 0, 0, 0, 0};
        vt[5]  = '{NOE, P0, NOE, 0, 0, 0,
                   1, 0, 1, 1, 4'd0, 32'h0008_0006, 32'h0008_0006, 0, 0, 0};
        vt[6]  = '{NOE, P0, NOE, 0, 0, 0,
                   0, 0, 0, 0, 4'd0, 32'h0008_0006, 32'h0008_0006, 1, 0, 0};
        vt[7]  = '{NOE, P0, NOE, 0, 1, 0,  1, 32'h0008_0006, 1, 0, 4'd0,
                   32'h0008_0006, 32'h0008_0006, 1, 0, 0};
        vt[8]  = '{NOE, P0, NOE, 0, 0, 0,
                   0, 0, 0, 0, NOE, 32'h0008_0006, 32'h0008_0006, 0, 0, 0};
        vt[9]  = '{NOE, 32'h0008_0010, NOE, 0, 0, 0,
                   0, 0, 0, 0, NOE, 32'h0008_0006, 32'h0008_0006, 0, 0, 0};
        vt[10] = '{NOE, P0, NOE, 0, 0, 0,
                   0, 0, 0, 0, NOE, 32'h0008_0006, 32'h0008_0006, 0, 0, 0};
        vt[11] = '{NOE, P0, 4'd5, 32'h1000, 0, 0,
                   1, 0, 1, 1, 4'd5, 32'h0008_0010, 32'h1000, 0, 0, 0};
        vt[12] = '{NOE, P0, NOE, 0, 0, 0,
                   0, 0, 0, 0, 4'd5, 32'h0008_0010, 32'h1000, 1, 0, 0};
        vt[13] = '{NOE, P0, NOE, 0, 1, 0,  1, 32'h0008_0010, 1, 0, 4'd5,
                   32'h0008_0010, 32'h1000, 1, 0, 0};
        vt[14] = '{NOE, P0, NOE, 0, 0, 0,
                   0, 0, 0, 0, NOE, 32'h0008_0010, 32'h1000, 0, 0, 0};
        vt[15] = '{4'd0, 32'h0008_0020, NOE, 0, 0, 0,
                   0, 0, 0, 0, NOE, 32'h0008_0010, 32'h1000, 0, 0, 0};
        vt[16] = '{NOE, P0, NOE, 0, 0, 0,
                   0, 0, 0, 0, NOE, 32'h0008_0010, 32'h1000, 0, 0, 0};
        vt[17] = '{NOE, P0, 4'd7, 32'h2000, 0, 0,
                   1, 0, 1, 1, 4'd0, 32'h0008_0020, 32'h0008_0020, 0, 0, 0};
        vt[18] = '{NOE, P0, NOE, 0, 0, 0,
                   0, 0, 0, 0, 4'd0, 32'h0008_0020, 32'h0008_0020, 1, 0, 0};
        vt[19] = '{NOE, P0, 4'd11, 0, 0, 0,
                   0, 0, 1, 0, 4'd0, 32'h0008_0020, 32'h0008_0020, 1, 0, 1};
        vt[20] = '{NOE, P0, NOE, 0, 0, 0,
                   0, 0, 1, 0, 4'd0, 32'h0008_0020, 32'h0008_0020, 1, 0, 1};

        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 21; i++) begin
            idle();
            code_f = vt[i].cf; pc_f = vt[i].pf; code_e = vt[i].ce;
            alu = vt[i].a; mret = vt[i].mr; rdone = vt[i].rd;
            tick();
            check($sformatf("vec%0d", i), dut_vec(),
                  {vt[i].ren, vt[i].tgt, vt[i].fl, vt[i].tt, vt[i].mc,
                   vt[i].mepc, vt[i].mtval, vt[i].tp, vt[i].rp, vt[i].h});
        end

        // Flushed fetch fault must never trap
        do_reset();
        rdone = 1; tick(); idle(); tick(); tick();
        code_f = 4'd2; pc_f = 32'h0008_0040; flush_d = 1;
        tick();
        idle();
        tcnt = 0;
        repeat (6) begin tick(); tcnt += int'(tt); end
        check1("flushed_no_trap", tcnt, 0);

        // Stalled E holding a fault traps exactly once
        code_f = 4'd2; pc_f = 32'h0008_0050;
        tick(); idle(); tick();
        tcnt = 0;
        stall_d = 1;
        repeat (3) begin tick(); tcnt += int'(tt); end
        stall_d = 0;
        repeat (4) begin tick(); tcnt += int'(tt); end
        check1("stall_one_trap", tcnt, 1);
        check1("stall_mtval", mtval, 32'h0008_0050);

        // Fault inside the handler halts; async reset recovers
        mret = 1; tick(); idle(); tick();
        code_e = 4'd6; alu = 32'h3000; tick(); idle(); tick();
        saved = m_mepc;
        code_e = 4'd11; tick(); idle();
        check1("halt_set", {h, fl}, 2'b11);
        tick(); tick();
        check1("halt_sticky", {h, fl}, 2'b11);
        check1("halt_mepc", mepc, saved);
        #2 rst = 1;
        #1;
        check1("async_rst", {h, rp, tp, mc}, {3'b010, NOE});
        model_reset();
        @(posedge clk); #1; rst = 0;

        // Random stimulus against the model
        for (int c = 0; c < 3000; c++) begin
            stall_f = ($urandom_range(0, 9) == 0);
            stall_d = ($urandom_range(0, 9) == 0);
            flush_d = ($urandom_range(0, 9) == 0);
            flush_e = ($urandom_range(0, 14) == 0);
            pc_f    = $urandom;
            alu     = $urandom;
            code_f  = NOE;
            code_e  = NOE;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 7))
                    0: code_f = 4'd0;
                    1: code_f = 4'd2;
                    2: code_f = 4'd11;
                    3: code_f = 4'd14;
                    default: code_f = NOE;
                endcase
            end
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 5))
                    0: code_e = 4'd4;
                    1: code_e = 4'd5;
                    2: code_e = 4'd6;
                    3: code_e = 4'd7;
                    4: code_e = 4'd11;
                    default: code_e = 4'd2;
                endcase
            end
            mret  = ($urandom_range(0, 5) == 0);
            rdone = ($urandom_range(0, 5) == 0);
            tick();
            if (m_mode == 3 || $urandom_range(0, 199) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
